// File: rtl/rename_pkg.sv
// rename_pkg: shared register-file types and rename configuration.
//   RegType_t   - operand class (none / GPR / FPR / ROB tag)
//   RegFile_t   - {regtype, addr[5:0]} operand descriptor
//   RobDepth    - default ROB entry count (cpu_config value)
//   NumGpr/NumFpr, MapEntries, MapIdxW - map table geometry
//   is_renamable(), map_idx() - shared helpers for map table addressing
package rename_pkg;

    // cpu_config
    localparam int unsigned RobDepth   = 32;

    // regfile
    localparam int unsigned NumGpr     = 32;
    localparam int unsigned NumFpr     = 32;
    localparam int unsigned MapEntries = NumGpr + NumFpr;
    localparam int unsigned MapIdxW    = $clog2(MapEntries);

    typedef enum logic [1:0] {
        TYPE_NONE = 2'd0,
        TYPE_GPR  = 2'd1,
        TYPE_FPR  = 2'd2,
        TYPE_ROB  = 2'd3
    } RegType_t;

    typedef struct packed {
        RegType_t   regtype;
        logic [5:0] addr;
    } RegFile_t;

    // GPR x0 is hardwired and never gets a map entry.
    function automatic logic is_renamable(RegFile_t r);
        return ((r.regtype == TYPE_GPR) && (r.addr[4:0] != 5'd0)) ||
               (r.regtype == TYPE_FPR);
    endfunction

    // GPRs occupy entries 0..31, FPRs 32..63.
    function automatic logic [MapIdxW-1:0] map_idx(RegFile_t r);
        return {r.regtype == TYPE_FPR, r.addr[4:0]};
    endfunction

endpackage

// File: rtl/rename_map_entry.sv
// rename_map_entry: one map-table slot (busy bit + owning ROB id).
//   clk, reset_    - clock, asynchronous active-low reset
//   flush          - clear busy (highest priority)
//   set/set_rob_id - allocate slot to a new ROB id (beats commit)
//   clr_e/clr_rob_id - commit; clears busy only if the slot still owns that id
//   busy, rob_id   - current slot state
module rename_map_entry #(
    parameter int unsigned ROB = 5
) (
    input  logic           clk,
    input  logic           reset_,
    input  logic           flush,
    input  logic           set,
    input  logic [ROB-1:0] set_rob_id,
    input  logic           clr_e,
    input  logic [ROB-1:0] clr_rob_id,
    output logic           busy,
    output logic [ROB-1:0] rob_id
);

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            busy   <= 1'b0;
            rob_id <= '0;
        end else if (flush) begin
            busy   <= 1'b0;
        end else if (set) begin
            busy   <= 1'b1;
            rob_id <= set_rob_id;
        end else if (clr_e && busy && (rob_id == clr_rob_id)) begin
            busy   <= 1'b0;
        end
    end

endmodule

// File: rtl/rename.sv
// rename: register rename map table with combinational lookup.
//   Optional feature: define RENAME_FLUSH_EN to add flush_ (active-low),
//   which clears every busy bit on the next edge, ahead of decode/commit.
// Ports:
//   clk, reset_                   - clock, asynchronous active-low reset
//   flush_                        - (RENAME_FLUSH_EN only) table flush
//   dec_e_, dec_invalid           - decode strobe (active-low) / invalid flag
//   dec_rd, dec_rs1, dec_rs2      - architectural operands
//   dec_rob_id                    - ROB id allocated to the decoded instr
//   ren_rs1, ren_rs2, ren_rd      - renamed operands (zero-cycle)
//   commit_e_, com_rob_id         - commit strobe (active-low) / committed id
module rename
    import rename_pkg::*;
#(
    parameter int unsigned ROB_DEPTH = RobDepth,
    localparam int unsigned ROB      = $clog2(ROB_DEPTH)
) (
    input  logic           clk,
    input  logic           reset_,
`ifdef RENAME_FLUSH_EN
    input  logic           flush_,
`endif
    input  logic           dec_e_,
    input  logic           dec_invalid,
    input  RegFile_t       dec_rd,
    input  RegFile_t       dec_rs1,
    input  RegFile_t       dec_rs2,
    input  logic [ROB-1:0] dec_rob_id,
    output RegFile_t       ren_rs1,
    output RegFile_t       ren_rs2,
    output RegFile_t       ren_rd,
    input  logic           commit_e_,
    input  logic [ROB-1:0] com_rob_id
);

    logic                  dec_valid;
    logic                  flush;
    logic [MapEntries-1:0] set_vec;
    logic [MapEntries-1:0] busy_vec;
    logic [ROB-1:0]        rob_vec [MapEntries];
    logic [MapIdxW-1:0]    rd_idx;
    logic [MapIdxW-1:0]    rs1_idx;
    logic [MapIdxW-1:0]    rs2_idx;
    logic                  unused_rd_hi;

    assign dec_valid = !dec_e_ && !dec_invalid;
    assign rd_idx    = map_idx(dec_rd);
    assign rs1_idx   = map_idx(dec_rs1);
    assign rs2_idx   = map_idx(dec_rs2);

    // Only addr[4:0] selects a map slot; the top bit of rd is not needed.
    assign unused_rd_hi = dec_rd.addr[5];

`ifdef RENAME_FLUSH_EN
    assign flush = !flush_;
`else
    assign flush = 1'b0;
`endif

    always_comb begin
        set_vec = '0;
        if (dec_valid && is_renamable(dec_rd)) begin
            set_vec[rd_idx] = 1'b1;
        end
    end

    for (genvar i = 0; i < MapEntries; i++) begin : g_map
        rename_map_entry #(
            .ROB(ROB)
        ) u_entry (
            .clk        (clk),
            .reset_     (reset_),
            .flush      (flush),
            .set        (set_vec[i]),
            .set_rob_id (dec_rob_id),
            .clr_e      (!commit_e_),
            .clr_rob_id (com_rob_id),
            .busy       (busy_vec[i]),
            .rob_id     (rob_vec[i])
        );
    end

    // Lookup reads the registered table, so a same-instruction rd update or
    // a same-cycle commit is only visible from the following cycle.
    function automatic RegFile_t lookup(RegFile_t src, logic busy, logic [ROB-1:0] id);
        RegFile_t r;
        r = src;
        if (is_renamable(src) && busy) begin
            r.regtype = TYPE_ROB;
            r.addr    = 6'(id);
        end
        return r;
    endfunction

    always_comb begin
        ren_rs1 = '{regtype: TYPE_NONE, addr: '0};
        ren_rs2 = '{regtype: TYPE_NONE, addr: '0};
        ren_rd  = '{regtype: TYPE_NONE, addr: '0};
        if (dec_valid) begin
            ren_rs1 = lookup(dec_rs1, busy_vec[rs1_idx], rob_vec[rs1_idx]);
            ren_rs2 = lookup(dec_rs2, busy_vec[rs2_idx], rob_vec[rs2_idx]);
            if (is_renamable(dec_rd)) begin
                ren_rd = '{regtype: TYPE_ROB, addr: 6'(dec_rob_id)};
            end
        end
    end

endmodule

// File: tb/tb_rename.sv
// tb_rename: directed vector table, reset/flush sequences and a randomized
// run against an array-based model of the rename map.
module tb_rename;
    import rename_pkg::*;

    localparam int RW = $clog2(RobDepth);

    logic           clk = 1'b0;
    logic           reset_;
`ifdef RENAME_FLUSH_EN
    logic           flush_;
`endif
    logic           dec_e_;
    logic           dec_invalid;
    RegFile_t       dec_rd, dec_rs1, dec_rs2;
    logic [RW-1:0]  dec_rob_id;
    RegFile_t       ren_rs1, ren_rs2, ren_rd;
    logic           commit_e_;
    logic [RW-1:0]  com_rob_id;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rename #(.ROB_DEPTH(RobDepth)) dut (
        .clk         (clk),
        .reset_      (reset_),
`ifdef RENAME_FLUSH_EN
        .flush_      (flush_),
`endif
        .dec_e_      (dec_e_),
        .dec_invalid (dec_invalid),
        .dec_rd      (dec_rd),
        .dec_rs1     (dec_rs1),
        .dec_rs2     (dec_rs2),
        .dec_rob_id  (dec_rob_id),
        .ren_rs1     (ren_rs1),
        .ren_rs2     (ren_rs2),
        .ren_rd      (ren_rd),
        .commit_e_   (commit_e_),
        .com_rob_id  (com_rob_id)
    );

    // Operand encodings: {type[1:0], addr[5:0]}; 0=none 1=gpr 2=fpr 3=rob.
    function automatic logic [7:0] gpr(int n);  return {2'd1, 6'(n)}; endfunction
    function automatic logic [7:0] fpr(int n);  return {2'd2, 6'(n)}; endfunction
    function automatic logic [7:0] robv(int n); return {2'd3, 6'(n)}; endfunction
    localparam logic [7:0] NONE = 8'h00;

    typedef struct {
        string      name;
        logic       de_n;
        logic       inv;
        logic [7:0] rd, rs1, rs2;
        int         rob;
        logic       ce_n;
        int         crob;
        logic [7:0] e_rs1, e_rs2, e_rd;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mkv(string name, logic de_n, logic inv,
                                 logic [7:0] rd, logic [7:0] rs1, logic [7:0] rs2, int rob,
                                 logic ce_n, int crob,
                                 logic [7:0] e1, logic [7:0] e2, logic [7:0] erd);
        vec_t v;
        v.name = name; v.de_n = de_n; v.inv = inv;
        v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.rob = rob;
        v.ce_n = ce_n; v.crob = crob;
        v.e_rs1 = e1; v.e_rs2 = e2; v.e_rd = erd;
        return v;
    endfunction

    task automatic chk(string name, logic [7:0] got, logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic drive(logic de_n, logic inv, logic [7:0] rd, logic [7:0] rs1,
                         logic [7:0] rs2, int rob, logic ce_n, int crob);
        dec_e_      = de_n;
        dec_invalid = inv;
        dec_rd      = RegFile_t'(rd);
        dec_rs1     = RegFile_t'(rs1);
        dec_rs2     = RegFile_t'(rs2);
        dec_rob_id  = RW'(rob);
        commit_e_   = ce_n;
        com_rob_id  = RW'(crob);
    endtask

    // Reference model: one busy flag and owner id per architectural register.
    bit m_busy [64];
    int m_rid  [64];

    function automatic bit m_renamable(logic [7:0] r);
        return (r[7:6] == 2'd1 && r[4:0] != 0) || r[7:6] == 2'd2;
    endfunction

    function automatic int m_idx(logic [7:0] r);
        return (r[7:6] == 2'd2 ? 32 : 0) + int'(r[4:0]);
    endfunction

    function automatic logic [7:0] m_src(bit valid, logic [7:0] s);
        if (!valid) return NONE;
        if (m_renamable(s) && m_busy[m_idx(s)]) return robv(m_rid[m_idx(s)]);
        return s;
    endfunction

    function automatic logic [7:0] rnd_reg();
        int t = int'($urandom_range(0, 3));
        if (t == 1 || t == 2) return {2'(t), 6'($urandom_range(0, 7))};
        return {2'(t), 6'($urandom_range(0, 63))};
    endfunction

    initial begin
        reset_ = 1'b0;
`ifdef RENAME_FLUSH_EN
        flush_ = 1'b1;
`endif
        drive(1'b1, 1'b0, NONE, NONE, NONE, 0, 1'b1, 0);

        // name, de_n, inv, rd, rs1, rs2, rob, ce_n, crob, exp rs1, exp rs2, exp rd
        vq.push_back(mkv("idle_after_reset", 1, 0, gpr(3), gpr(1), gpr(2), 0, 1, 0, NONE, NONE, NONE));
        vq.push_back(mkv("rename_g1_r4",     0, 0, gpr(1), gpr(1), gpr(2), 4, 1, 0, gpr(1), gpr(2), robv(4)));
        vq.push_back(mkv("read_g1",          0, 0, NONE,   gpr(1), gpr(2), 0, 1, 0, robv(4), gpr(2), NONE));
        vq.push_back(mkv("remap_g1_r5",      0, 0, gpr(1), gpr(1), gpr(2), 5, 1, 0, robv(4), gpr(2), robv(5)));
        vq.push_back(mkv("read_r5_commit4",  0, 0, NONE,   gpr(1), gpr(2), 0, 0, 4, robv(5), gpr(2), NONE));
        vq.push_back(mkv("stale_commit",     0, 0, NONE,   gpr(1), gpr(2), 0, 0, 5, robv(5), gpr(2), NONE));
        vq.push_back(mkv("after_commit5",    0, 0, NONE,   gpr(1), gpr(2), 0, 1, 0, gpr(1), gpr(2), NONE));
        vq.push_back(mkv("self_ref",         0, 0, gpr(3), gpr(3), gpr(1), 7, 1, 0, gpr(3), gpr(1), robv(7)));
        vq.push_back(mkv("read_g3_rd_x0",    0, 0, gpr(0), gpr(3), gpr(0), 2, 1, 0, robv(7), gpr(0), NONE));
        vq.push_back(mkv("x0_invalid_dec",   0, 1, gpr(4), gpr(0), gpr(3), 6, 1, 0, NONE, NONE, NONE));
        vq.push_back(mkv("no_change_check",  0, 0, NONE,   gpr(0), gpr(4), 0, 1, 0, gpr(0), gpr(4), NONE));
        vq.push_back(mkv("fpr_rename",       0, 0, fpr(3), fpr(3), gpr(3), 9, 1, 0, fpr(3), robv(7), robv(9)));
        vq.push_back(mkv("fpr_read_g1_r4",   0, 0, gpr(1), fpr(3), gpr(3), 4, 1, 0, robv(9), robv(7), robv(4)));
        vq.push_back(mkv("conflict",         0, 0, gpr(1), gpr(1), fpr(3), 9, 0, 4, robv(4), robv(9), robv(9)));
        vq.push_back(mkv("after_conflict",   0, 0, NONE,   gpr(1), fpr(3), 0, 0, 9, robv(9), robv(9), NONE));
        vq.push_back(mkv("commit9_both",     0, 0, NONE,   gpr(1), fpr(3), 0, 1, 0, gpr(1), fpr(3), NONE));
        vq.push_back(mkv("passthru_rob",     0, 0, gpr(5), robv(5), 8'h03, 3, 1, 0, robv(5), 8'h03, robv(3)));
        vq.push_back(mkv("commit_disabled",  0, 0, NONE,   gpr(5), gpr(3), 0, 1, 3, robv(3), robv(7), NONE));
        vq.push_back(mkv("still_busy",       0, 0, NONE,   gpr(5), gpr(0), 0, 1, 0, robv(3), gpr(0), NONE));

        repeat (2) @(negedge clk);
        #1;
        chk("reset_rs1", ren_rs1, NONE);
        chk("reset_rd",  ren_rd,  NONE);
        reset_ = 1'b1;

        foreach (vq[i]) begin
            @(negedge clk);
            drive(vq[i].de_n, vq[i].inv, vq[i].rd, vq[i].rs1, vq[i].rs2,
                  vq[i].rob, vq[i].ce_n, vq[i].crob);
            #1;
            chk({vq[i].name, ".rs1"}, ren_rs1, vq[i].e_rs1);
            chk({vq[i].name, ".rs2"}, ren_rs2, vq[i].e_rs2);
            chk({vq[i].name, ".rd"},  ren_rd,  vq[i].e_rd);
        end

        // Asynchronous reset in the middle of a cycle with entries busy.
        @(negedge clk); drive(0, 0, gpr(6), NONE, NONE, 1, 1, 0);
        @(negedge clk); drive(0, 0, fpr(7), NONE, NONE, 2, 1, 0);
        @(negedge clk); drive(0, 0, NONE, gpr(6), fpr(7), 0, 1, 0);
        #1;
        chk("pre_reset_rs1", ren_rs1, robv(1));
        chk("pre_reset_rs2", ren_rs2, robv(2));
        #1 reset_ = 1'b0;
        #1;
        chk("in_reset_rs1", ren_rs1, gpr(6));
        chk("in_reset_rs2", ren_rs2, fpr(7));
        #1 reset_ = 1'b1;
        @(negedge clk); #1;
        chk("post_reset_rs1", ren_rs1, gpr(6));
        chk("post_reset_rs2", ren_rs2, fpr(7));

`ifdef RENAME_FLUSH_EN
        @(negedge clk); drive(0, 0, gpr(6), NONE, NONE, 1, 1, 0);
        @(negedge clk); drive(0, 0, gpr(8), gpr(6), NONE, 3, 0, 1);
        #1;
        chk("pre_flush_rs1", ren_rs1, robv(1));
        flush_ = 1'b0;
        @(negedge clk);
        flush_ = 1'b1;
        drive(0, 0, NONE, gpr(6), gpr(8), 0, 1, 0);
        #1;
        chk("post_flush_rs1", ren_rs1, gpr(6));
        chk("post_flush_rs2", ren_rs2, gpr(8));
`endif

        @(negedge clk); drive(1, 0, NONE, NONE, NONE, 0, 1, 0);
        for (int k = 0; k < 64; k++) begin
            m_busy[k] = 1'b0;
            m_rid[k]  = 0;
        end

        for (int c = 0; c < 400; c++) begin
            logic       de_n, inv, ce_n, valid;
            logic [7:0] rd, rs1, rs2;
            int         rob, crob;
            @(negedge clk);
            de_n = ($urandom_range(0, 7) == 0);
            inv  = ($urandom_range(0, 7) == 0);
            rd   = rnd_reg();
            rs1  = rnd_reg();
            rs2  = rnd_reg();
            rob  = int'($urandom_range(0, 7));
            ce_n = ($urandom_range(0, 1) == 0);
            crob = int'($urandom_range(0, 7));
            drive(de_n, inv, rd, rs1, rs2, rob, ce_n, crob);
            #1;
            valid = !de_n && !inv;
            chk("rand_rs1", ren_rs1, m_src(valid, rs1));
            chk("rand_rs2", ren_rs2, m_src(valid, rs2));
            chk("rand_rd",  ren_rd,  (valid && m_renamable(rd)) ? robv(rob) : NONE);
            // State after the coming edge: commit clears, then decode allocates.
            if (!ce_n) begin
                for (int k = 0; k < 64; k++) begin
                    if (m_busy[k] && m_rid[k] == crob) m_busy[k] = 1'b0;
                end
            end
            if (valid && m_renamable(rd)) begin
                m_busy[m_idx(rd)] = 1'b1;
                m_rid[m_idx(rd)]  = rob;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
